morse_tx: RTL
=============

Name: morse_tx

Overview:
- Morse keyer: the transmit end of the morse link, turning ASCII characters into timed key-on/key-off output.
- Its output is what the receive-side decoder turns back into the character shown by the VGA pattern renderer.
- Accepts one character per valid/ready handshake, looks up its dot/dash pattern and drives oKey with standard unit timing.
- Echoes the character in flight so the display buffer can show what is being sent.

Parameters:
- UNIT_CYCLES, 1200000: clock cycles per Morse time unit (dot length); must be >= 2.
- CW, 21: width of the unit cycle counter; must satisfy 2^CW > UNIT_CYCLES.

Ports:
- iCLK  input  1  system clock.
- iRST  input  1  synchronous active-high reset.
- iChar  input  8  ASCII character to send.
- iValid  input  1  iChar is valid.
- oReady  output  1  block can accept a character this cycle.
- oKey  output  1  keyed output; 1 = tone/mark, 0 = silence.
- oBusy  output  1  a character is being sent (any state other than IDLE).
- oChar  output  8  character currently being sent; holds the last accepted character when idle.
- oErr  output  1  one-cycle pulse when an unsupported character is accepted.

Behaviour:
- Interface decision: one clock, iCLK; reset iRST is synchronous and active-high.
- Reset values: oKey=0, oBusy=0, oErr=0, oChar=8'h20, state IDLE, all counters 0. oReady=1 on the first cycle after reset is released.
- Registered outputs: every output is registered except oReady, which equals (state==IDLE).
- Handshake: accept on a rising edge with iValid && oReady. iChar is captured into oChar on that edge. iValid while busy is ignored; the source must hold it.
- Supported set: A-Z, a-z (same codes as A-Z), 0-9, space (8'h20).
- Lookup: supported letters/digits map to length L (1..5) and pattern bits (1 = dash), first element in the MSB of the used bits. International Morse, e.g. A=.-, E=., T=-, 0=-----, 5=......
- Unsupported characters: oErr=1 for exactly the cycle after accept. oChar updates, state stays IDLE, oKey stays 0, oReady stays 1.
- States and transitions:
  - IDLE -> MARK on accept of a letter/digit: element index 0, oKey=1 from the next cycle.
  - IDLE -> WORD on accept of a space.
  - MARK: oKey=1 for exactly 1*UNIT_CYCLES (dot) or 3*UNIT_CYCLES (dash) cycles. Then -> GAP if elements remain, else -> CHARGAP.
  - GAP: oKey=0 for 1*UNIT_CYCLES, then -> MARK with the next element.
  - CHARGAP: oKey=0 for 3*UNIT_CYCLES, then -> IDLE.
  - WORD: oKey=0 for 4*UNIT_CYCLES (preceding CHARGAP 3 + 4 = 7-unit word space), then -> IDLE.
- Timing: a single unit counter counts 0..UNIT_CYCLES-1; a unit counter (max 4) counts units within a state. Both clear on every state change. No drift: each state lasts an exact multiple of UNIT_CYCLES cycles.
- Latency: oKey rises on the first cycle after the accept edge. oReady reasserts on the first cycle after the final CHARGAP/WORD cycle.
- Back-to-back: a new character may be accepted the same cycle oReady reasserts; it adds no extra gap.
- Reset mid-operation: on the next edge oKey=0, state IDLE, the partial character is discarded, and oChar returns to 8'h20.
- iValid with iRST high: ignored.

Test Plan:
- UNIT_CYCLES=4, send "E" -> oKey=1 for 4 cycles starting 1 cycle after accept, then 0 for 12 cycles; oReady=1 at cycle 17 after accept; oChar=8'h45, oBusy=1 for cycles 1..16.
- UNIT_CYCLES=4, send "a" -> oKey high 4, low 4, high 12, low 12; oReady at cycle 33; oErr never asserts.
- UNIT_CYCLES=4, send "0" then "T" back-to-back with iValid held high:
  - "0": five 12-cycle marks separated by 4-cycle gaps, then a 12-cycle gap.
  - "T": accepted on the cycle oReady rises, then a 12-cycle mark.
  - No extra idle cycle between the two characters.
- UNIT_CYCLES=4, send "#" (8'h23) -> oErr=1 for exactly 1 cycle, oKey stays 0, oReady never drops, oChar=8'h23.
- UNIT_CYCLES=4, send " " after "E" -> after E's 12-cycle gap, 16 more cycles of oKey=0 with oBusy=1, oChar=8'h20; total silence 28 cycles.
- UNIT_CYCLES=4, assert iRST for 1 cycle during the 6th cycle of a dash -> next cycle oKey=0, oBusy=0, oReady=1, oChar=8'h20; a following "E" times correctly.

Source files
------------

// File: rtl/morse_tx.sv
// Morse keyer: accepts one ASCII character per valid/ready handshake and keys
// oKey with standard unit timing (dot 1, dash 3, element gap 1, char gap 3, word +4).
//
// state   | meaning
// IDLE    | waiting for a character, oReady high
// MARK    | key down for one element (1 unit dot, 3 units dash)
// GAP     | key up for 1 unit between elements of one character
// CHARGAP | key up for 3 units after the last element
// WORD    | key up for 4 units after a space (7 units with the preceding CHARGAP)
module morse_tx #(
  parameter int UNIT_CYCLES = 1200000,
  parameter int CW          = 21
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iChar,
  input  logic       iValid,
  output logic       oReady,
  output logic       oKey,
  output logic       oBusy,
  output logic [7:0] oChar,
  output logic       oErr
);

  typedef enum logic [2:0] {IDLE, MARK, GAP, CHARGAP, WORD} stateT;

  stateT state, stateNext;

  logic [CW-1:0] unitCnt;
  logic [2:0]    unitNum;
  logic [2:0]    elemIdx;
  logic [2:0]    elemLen;
  logic [4:0]    pattern;
  logic [2:0]    durUnits;
  logic [2:0]    bitIdx;
  logic [7:0]    upper;
  logic [7:0]    lookup;
  logic          unitDone, stateDone, isDash, accept, charOk, isSpace;

  // Returns {length[2:0], pattern[4:0]}; pattern right-aligned, 1 = dash,
  // first element in the MSB of the used bits. Length 0 means unsupported.
  function automatic logic [7:0] morseLookup(input logic [7:0] c);
    case (c)
      8'h41: return {3'd2, 5'b00001}; // A
      8'h42: return {3'd4, 5'b01000};
      8'h43: return {3'd4, 5'b01010};
      8'h44: return {3'd3, 5'b00100};
      8'h45: return {3'd1, 5'b00000};
      8'h46: return {3'd4, 5'b00010};
      8'h47: return {3'd3, 5'b00110};
      8'h48: return {3'd4, 5'b00000};
      8'h49: return {3'd2, 5'b00000};
      8'h4A: return {3'd4, 5'b00111};
      8'h4B: return {3'd3, 5'b00101};
      8'h4C: return {3'd4, 5'b00100};
      8'h4D: return {3'd2, 5'b00011};
      8'h4E: return {3'd2, 5'b00010};
      8'h4F: return {3'd3, 5'b00111};
      8'h50: return {3'd4, 5'b00110};
      8'h51: return {3'd4, 5'b01101};
      8'h52: return {3'd3, 5'b00010};
      8'h53: return {3'd3, 5'b00000};
      8'h54: return {3'd1, 5'b00001};
      8'h55: return {3'd3, 5'b00001};
      8'h56: return {3'd4, 5'b00001};
      8'h57: return {3'd3, 5'b00011};
      8'h58: return {3'd4, 5'b01001};
      8'h59: return {3'd4, 5'b01011};
      8'h5A: return {3'd4, 5'b01100}; // Z
      8'h30: return {3'd5, 5'b11111}; // 0
      8'h31: return {3'd5, 5'b01111};
      8'h32: return {3'd5, 5'b00111};
      8'h33: return {3'd5, 5'b00011};
      8'h34: return {3'd5, 5'b00001};
      8'h35: return {3'd5, 5'b00000};
      8'h36: return {3'd5, 5'b10000};
      8'h37: return {3'd5, 5'b11000};
      8'h38: return {3'd5, 5'b11100};
      8'h39: return {3'd5, 5'b11110}; // 9
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    upper   = ((iChar >= 8'h61) && (iChar <= 8'h7A)) ? (iChar - 8'h20) : iChar;
    lookup  = morseLookup(upper);
    charOk  = (lookup[7:5] != 3'd0);
    isSpace = (iChar == 8'h20);
    oReady  = (state == IDLE);
    accept  = iValid && oReady;
    bitIdx  = elemLen - 3'd1 - elemIdx;
    isDash  = pattern[bitIdx];
  end

  always_comb begin
    durUnits = 3'd1;
    case (state)
      MARK:    durUnits = isDash ? 3'd3 : 3'd1;
      GAP:     durUnits = 3'd1;
      CHARGAP: durUnits = 3'd3;
      WORD:    durUnits = 3'd4;
      default: durUnits = 3'd1;
    endcase
    unitDone  = (unitCnt == CW'(UNIT_CYCLES - 1));
    stateDone = unitDone && (unitNum == durUnits - 3'd1);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept && charOk)
          stateNext = MARK;
        else if (accept && isSpace)
          stateNext = WORD;
      end
      MARK: begin
        if (stateDone)
          stateNext = (elemIdx == elemLen - 3'd1) ? CHARGAP : GAP;
      end
      GAP: begin
        if (stateDone)
          stateNext = MARK;
      end
      CHARGAP, WORD: begin
        if (stateDone)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      unitCnt <= '0;
      unitNum <= '0;
      elemIdx <= '0;
      elemLen <= '0;
      pattern <= '0;
      oKey    <= 1'b0;
      oBusy   <= 1'b0;
      oErr    <= 1'b0;
      oChar   <= 8'h20;
    end else begin
      state <= stateNext;
      // Counters restart on every state change so each state is an exact multiple of a unit
      if ((stateNext != state) || (state == IDLE)) begin
        unitCnt <= '0;
        unitNum <= '0;
      end else if (unitDone) begin
        unitCnt <= '0;
        unitNum <= unitNum + 3'd1;
      end else begin
        unitCnt <= unitCnt + CW'(1);
      end

      if (accept) begin
        oChar   <= iChar;
        elemLen <= lookup[7:5];
        pattern <= lookup[4:0];
        elemIdx <= '0;
      end else if ((state == GAP) && (stateNext == MARK)) begin
        elemIdx <= elemIdx + 3'd1;
      end

      oKey  <= (stateNext == MARK);
      oBusy <= (stateNext != IDLE);
      oErr  <= accept && !charOk && !isSpace;
    end
  end

endmodule
